// File: rtl/mips_mem_responder.sv
// mips_mem_responder: single-outstanding word memory endpoint for the
// multicycle MIPS core's instruction-fetch and data-memory cycles.
// A request is accepted over a valid/ready handshake, the array is accessed
// WAIT_CYCLES cycles later, and the result is returned over a separate
// valid/ready response channel.
// Optional build macro MEM_ALIGN_CHECK_EN: when defined, a byte address with
// nonzero bits [1:0] is rejected like an out-of-range access.
//
// state  | meaning
// IDLE   | waiting for a request; req_ready high
// ACCESS | counting down wait states; array access on terminal count
// RESP   | response presented, held until rsp_ready
module mips_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               bad_q, bad_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  logic [31:0]        mem [0:(1<<ADDR_W)-1];
  logic               req_bad;
  logic               mem_we;

  // Reject addresses beyond the array (and, optionally, misaligned ones).
`ifdef MEM_ALIGN_CHECK_EN
  assign req_bad = (|req_addr[31:ADDR_W+2]) | (|req_addr[1:0]);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign req_bad = |req_addr[31:ADDR_W+2];
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

  // Array write fires on the terminal-count cycle of a good write request.
  assign mem_we = (state_q == ACCESS) && (cnt_q == 4'd0) && we_q && !bad_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    bad_d       = bad_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          wdata_d = req_wdata;
          idx_d   = req_addr[ADDR_W+1:2];
          bad_d   = req_bad;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bad_q;
          rsp_rdata_d = (we_q || bad_q) ? 32'd0 : mem[idx_q];
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      idx_q       <= '0;
      bad_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      bad_q       <= bad_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  // Memory array; reset aborts a pending write but never clears contents.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

`ifndef SYNTHESIS
  // The wait-state counter is 4 bits wide.
  wait_cycles_legal: assert property (@(posedge clk) (WAIT_CYCLES >= 0) && (WAIT_CYCLES <= 15));
`endif

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the multicycle MIPS core's instruction-fetch and data-memory accesses.
- Accepts one word request at a time over a valid/ready handshake and performs the read or write after a programmable number of wait states.
- Returns the result over a separate valid/ready response channel.
- Serves as the IM/DM endpoint that the controller's fetch, memory-read and memory-write cycles target.

Parameters:
ADDR_W, 10, word-index width; memory depth = 2^ADDR_W 32-bit words
WAIT_CYCLES, 2, extra cycles between request accept and array access; legal range 0..15

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  reset, synchronous, active-low (rst==0 at posedge resets)
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  32  byte address
req_wdata  input  32  write data
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  read data; 0 for writes and errors
rsp_err  output  1  out-of-range (or misaligned, see option) access
busy  output  1  high whenever the state is not IDLE

Behaviour:
- States: IDLE, ACCESS, RESP. All outputs are registered except req_ready = (state==IDLE), which is combinational.
- Reset (rst==0 at posedge): state<=IDLE, rsp_valid<=0, rsp_rdata<=0, rsp_err<=0, busy<=0, wait counter<=0. Memory array is not cleared.
- Reset has priority over every other event, including mid-ACCESS and mid-RESP.
- Reset during ACCESS aborts the operation: no write occurs and any pending response is discarded.
- IDLE:
  - On req_valid && req_ready at posedge, latch req_we, req_wdata and word index req_addr[ADDR_W+1:2].
  - Set range flag = (req_addr[31:ADDR_W+2] != 0).
  - Load wait counter with WAIT_CYCLES, then go to ACCESS.
  - req_valid without a handshake has no effect.
- ACCESS:
  - If counter != 0: decrement and stay in ACCESS.
  - If counter == 0: perform the access and go to RESP with rsp_valid<=1.
  - Read: rsp_rdata<=mem[idx], rsp_err<=0.
  - Write: mem[idx]<=wdata, rsp_rdata<=0, rsp_err<=0.
  - Range flag set: no write, rsp_rdata<=0, rsp_err<=1.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready is sampled high.
  - On the handshake go to IDLE; rsp_valid<=0, while rsp_rdata and rsp_err hold their values.
  - req_valid is ignored in RESP (req_ready=0).
- Latency: request accepted at edge N -> rsp_valid high after edge N+1+WAIT_CYCLES.
- With rsp_ready tied high, the minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- Write-then-read to the same index returns the new data; writes complete before their response is issued.
- Counter width is 4 bits. A WAIT_CYCLES value above 15 is a configuration error, checked with a simulation-only assertion.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a request with req_addr[1:0] != 0 is treated like an out-of-range access. No write occurs, rsp_rdata=0, rsp_err=1. The response still follows normal latency.
- Undefined: req_addr[1:0] is ignored, and only the range check drives rsp_err.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release -> req_ready=1, rsp_valid=0, busy=0, rsp_rdata=0.
- Write/read, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to byte address 0x10 -> rsp_valid rises 3 edges after accept, with rsp_err=0 and rsp_rdata=0.
  - Then read 0x10 -> rsp_rdata=0xDEADBEEF.
- Backpressure: hold rsp_ready=0 for 5 cycles after read response -> rsp_valid/rsp_rdata stable, req_ready=0, a new req_valid is not accepted. Raise rsp_ready -> IDLE next cycle.
- Out of range, ADDR_W=10:
  - Write 0x12345678 to 0x1000 -> rsp_err=1.
  - Subsequent read of 0x0 -> value unchanged from before.
- Reset mid-operation: assert rst=0 during ACCESS of write 0xA5A5A5A5 to 0x20 -> no response. A later read of 0x20 returns the prior contents.
- MEM_ALIGN_CHECK_EN defined: write 0x11111111 to 0x22 -> rsp_err=1 and word 0x20 is unchanged. With the macro undefined, the same write updates word 0x20 and rsp_err=0.
